// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access,
// with a bounded data streak so a waiting fetch cannot starve.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          stall_f,
    output logic          stall_m
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t     r_state;
    logic [2:0] r_streak;
    logic       w_f_elig, w_d_elig, w_d_win, w_misal;
    // A requester whose ready is pulsing this cycle is still holding its old req.
    assign w_f_elig = if_req & ~if_ready;
    assign w_d_elig = d_req & ~d_ready;
    assign w_d_win  = w_d_elig & (~w_f_elig | (32'(r_streak) < MAX_D_STREAK));
    assign w_misal  = |d_addr[1:0];
    assign stall_f  = if_req & ~if_ready;
    assign stall_m  = d_req & ~d_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_streak  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            d_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_d_win && w_misal) begin
                        d_ready <= 1'b1;
                        d_err   <= 1'b1;
                    end else if (w_d_win) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        r_streak  <= w_f_elig ? r_streak + 3'd1 : 3'd0;
                        r_state   <= BUSY_D;
                    end else if (w_f_elig) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        r_streak <= 3'd0;
                        r_state  <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                        r_state  <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        d_ready <= 1'b1;
                        d_rdata <= mem_rdata;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for reset,
// misalignment and the data-streak limit.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, d_err, mem_req, mem_we, stall_f, stall_m;
    int          n_chk = 0, n_err = 0;

    mem_arbiter #(.MAX_D_STREAK(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    // ctl = {rst, if_req, d_req, d_we}; ef = {mem_req, mem_we, if_ready, d_ready, d_err, stall_f, stall_m}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] ia, da, dw;
        logic        ack;
        logic [31:0] mrd;
        logic [6:0]  ef;
        logic [31:0] ea, ew, eird, edrd;
    } vec_t;
    vec_t v[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g[10];
        int          ng;
        logic        prev;
        v[0]  = '{4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h0, 32'h0};
        v[1]  = '{4'b0111, 32'h40, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 7'b0000011, 32'h0, 32'h0, 32'h0, 32'h0};
        v[2]  = '{4'b1111, 32'h40, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 7'b1100011, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0};
        v[3]  = '{4'b1111, 32'h40, 32'h10, 32'hDEADBEEF, 1'b1, 32'hCAFE0001, 7'b0001010, 32'h0, 32'h0, 32'h0, 32'hCAFE0001};
        v[4]  = '{4'b1100, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 7'b1000010, 32'h40, 32'h0, 32'h0, 32'hCAFE0001};
        v[5]  = '{4'b1100, 32'h40, 32'h0, 32'h0, 1'b1, 32'h11112222, 7'b0010000, 32'h0, 32'h0, 32'h11112222, 32'hCAFE0001};
        v[6]  = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h11112222, 32'hCAFE0001};
        v[7]  = '{4'b1100, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 7'b1000010, 32'h40, 32'h0, 32'h11112222, 32'hCAFE0001};
        v[8]  = '{4'b1100, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 7'b1000010, 32'h40, 32'h0, 32'h11112222, 32'hCAFE0001};
        v[9]  = '{4'b1100, 32'h40, 32'h0, 32'h0, 1'b1, 32'h20080005, 7'b0010000, 32'h0, 32'h0, 32'h20080005, 32'hCAFE0001};
        v[10] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h20080005, 32'hCAFE0001};
        v[11] = '{4'b1010, 32'h0, 32'h13, 32'h0, 1'b0, 32'h0, 7'b0001100, 32'h0, 32'h0, 32'h20080005, 32'hCAFE0001};
        v[12] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h20080005, 32'hCAFE0001};
        v[13] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b1, 32'hBAD0BAD0, 7'b0000000, 32'h0, 32'h0, 32'h20080005, 32'hCAFE0001};
        v[14] = '{4'b1010, 32'h0, 32'h24, 32'h0, 1'b0, 32'h0, 7'b1000001, 32'h24, 32'h0, 32'h20080005, 32'hCAFE0001};
        v[15] = '{4'b1010, 32'h0, 32'h24, 32'h0, 1'b1, 32'h12345678, 7'b0001000, 32'h0, 32'h0, 32'h20080005, 32'h12345678};
        v[16] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h20080005, 32'h12345678};
        v[17] = '{4'b1011, 32'h0, 32'h30, 32'h55AA55AA, 1'b0, 32'h0, 7'b1100001, 32'h30, 32'h55AA55AA, 32'h20080005, 32'h12345678};
        v[18] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b1100000, 32'h30, 32'h55AA55AA, 32'h20080005, 32'h12345678};
        v[19] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D, 7'b0001000, 32'h0, 32'h0, 32'h20080005, 32'h0BADF00D};
        v[20] = '{4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h20080005, 32'h0BADF00D};
        #2;
        for (int i = 0; i < 21; i++) begin
            {rst, if_req, d_req, d_we} = v[i].ctl;
            if_addr = v[i].ia; d_addr = v[i].da; d_wdata = v[i].dw;
            mem_ack = v[i].ack; mem_rdata = v[i].mrd;
            tick();
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(v[i].ef[6]));
            chk($sformatf("v%0d if_ready", i), 32'(if_ready), 32'(v[i].ef[4]));
            chk($sformatf("v%0d d_ready", i), 32'(d_ready), 32'(v[i].ef[3]));
            chk($sformatf("v%0d d_err", i), 32'(d_err), 32'(v[i].ef[2]));
            chk($sformatf("v%0d stall_f", i), 32'(stall_f), 32'(v[i].ef[1]));
            chk($sformatf("v%0d stall_m", i), 32'(stall_m), 32'(v[i].ef[0]));
            chk($sformatf("v%0d if_rdata", i), if_rdata, v[i].eird);
            chk($sformatf("v%0d d_rdata", i), d_rdata, v[i].edrd);
            if (v[i].ef[6]) begin
                chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v[i].ef[5]));
                chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].ea);
            end
            if (v[i].ef[6] && v[i].ef[5])
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].ew);
            if (!v[i].ctl[3]) begin
                chk($sformatf("v%0d rst mem_addr", i), mem_addr, 32'h0);
                chk($sformatf("v%0d rst mem_wdata", i), mem_wdata, 32'h0);
                chk($sformatf("v%0d rst mem_we", i), 32'(mem_we), 32'h0);
            end
        end
        // Reset in the middle of a data access, then a stale ack after release.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_ack = 1'b0;
        tick();
        chk("midrst busy", 32'(mem_req), 32'h1);
        d_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst async mem_req", 32'(mem_req), 32'h0);
        chk("midrst async d_rdata", d_rdata, 32'h0);
        tick();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        tick();
        chk("midrst late ack d_ready", 32'(d_ready), 32'h0);
        chk("midrst late ack mem_req", 32'(mem_req), 32'h0);
        chk("midrst late ack d_rdata", d_rdata, 32'h0);
        mem_ack = 1'b0; d_req = 1'b1; d_addr = 32'h44;
        tick();
        chk("midrst regrant mem_req", 32'(mem_req), 32'h1);
        chk("midrst regrant mem_addr", mem_addr, 32'h44);
        mem_ack = 1'b1; mem_rdata = 32'h00000077;
        tick();
        chk("midrst regrant d_ready", 32'(d_ready), 32'h1);
        chk("midrst regrant d_rdata", d_rdata, 32'h00000077);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();
        // Streak limit: both sides request again one cycle after each completion.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b1; d_wdata = 32'hA5A5A5A5;
        for (int k = 0; k < 10; k++) g[k] = 32'h0;
        ng = 0;
        prev = 1'b0;
        for (int c = 0; c < 300 && ng < 10; c++) begin
            if_req = !(if_ready || d_ready);
            d_req = if_req;
            mem_ack = mem_req;
            tick();
            if (mem_req && !prev) begin
                g[ng] = mem_addr;
                ng++;
            end
            prev = mem_req;
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        chk("starve grant count", 32'(ng), 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("starve grant %0d", k), g[k], (k % 5 == 4) ? 32'h100 : 32'h200);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_D_STREAK, 4, max consecutive data grants while a fetch request waits.
REQ-002 Parameter: AW, 32, address width; the data width is fixed at 32.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch request; held high until if_ready.
REQ-006 if_addr  in  AW  fetch word address (pc).
REQ-007 if_rdata  out  32  fetched instruction; valid while if_ready=1.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request; held high until d_ready.
REQ-010 d_we  in  1  1=store, 0=load.
REQ-011 d_addr  in  AW  data byte address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_rdata  out  32  load data; valid while d_ready=1.
REQ-014 d_ready  out  1  one-cycle data completion pulse.
REQ-015 d_err  out  1  misaligned-access pulse, coincident with d_ready.
REQ-016 mem_req  out  1  shared memory request; held until mem_ack.
REQ-017 mem_we  out  1  shared memory write enable.
REQ-018 mem_addr  out  AW  shared memory address.
REQ-019 mem_wdata  out  32  shared memory write data.
REQ-020 mem_rdata  in  32  memory read data; valid with mem_ack.
REQ-021 mem_ack  in  1  memory completion, one cycle, at least one cycle after mem_req rises.
REQ-022 stall_f  out  1  combinational: if_req & ~if_ready.
REQ-023 stall_m  out  1  combinational: d_req & ~d_ready.

Function
REQ-024 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-025 A requester SHALL be eligible in IDLE only if its req=1 and its ready=0 in that cycle.
REQ-026 IDLE grant SHALL go to data if data is eligible and (fetch is not eligible or streak<MAX_D_STREAK), else to fetch if fetch is eligible, else stay IDLE.
REQ-027 On a grant, mem_addr, mem_we and mem_wdata SHALL be registered from the winner, and mem_req SHALL be 1 from the next cycle.
REQ-028 A fetch grant SHALL force mem_we=0.
REQ-029 mem_addr, mem_we, mem_wdata and mem_req SHALL remain stable in BUSY_x until the mem_ack cycle.
REQ-030 On mem_ack in BUSY_x, the FSM SHALL return to IDLE and mem_req SHALL drop at the same edge.
REQ-031 On that same edge, the matching ready SHALL pulse high for one cycle, with the rdata output registered from mem_rdata.
REQ-032 The rdata outputs SHALL hold their last value outside ready; they SHALL be 0 after reset.
REQ-033 mem_ack outside BUSY_x SHALL be ignored.
REQ-034 Minimum latency SHALL be: request in IDLE at cycle t -> mem_req at t+1 -> ack at t+1+k (k>=1) -> ready at t+2+k.
REQ-035 Streak counter: 3 bits, saturating at MAX_D_STREAK.
REQ-036 The streak counter SHALL increment on a data grant made while fetch is eligible.
REQ-037 The streak counter SHALL clear on a fetch grant or on a data grant made while fetch is not eligible.
REQ-038 With d_addr[1:0]!=0 and data winning in IDLE, no memory access SHALL be issued.
REQ-039 In that case, d_ready and d_err SHALL pulse at the next edge, d_rdata SHALL be unchanged, the FSM SHALL stay IDLE and the streak SHALL be unchanged.
REQ-040 Fetch addresses SHALL be driven unmodified; alignment is the fetch stage's job.
REQ-041 A req deasserted while the FSM is BUSY for it SHALL NOT abort the access; completion SHALL still pulse ready.

Reset
REQ-042 While rst=0, all of the following SHALL be 0, asynchronously: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, d_err, if_rdata, d_rdata, streak; the FSM SHALL be IDLE.
REQ-043 Reset mid-access SHALL drop mem_req immediately; no ready pulse SHALL follow, and any late mem_ack SHALL be ignored.
REQ-044 The first grant SHALL be possible on the first rising edge with rst=1.

Verification
REQ-045 Fetch only: if_req=1, if_addr=0x0000_0040, mem_ack 2 cycles after mem_req, mem_rdata=0x2008_0005 -> mem_req for exactly 2 cycles, if_ready=1 with if_rdata=0x2008_0005 one cycle later, stall_f=0 after.
REQ-046 Simultaneous requests: if_req=d_req=1 at reset release, d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF -> data served first (mem_we=1, mem_addr=0x10), then fetch (mem_we=0).
REQ-047 Starvation: if_req and d_req held high continuously, each ack after 1 cycle, MAX_D_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
REQ-048 Misaligned: d_req=1, d_addr=0x13 -> no mem_req, d_ready=d_err=1 at the next edge, stall_m=0 afterwards.
REQ-049 Reset mid-access: rst=0 while in BUSY_D -> mem_req=0 in the same cycle; a mem_ack delivered after release produces no d_ready; the next d_req is granted normally.
